// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the 4004 machine-cycle sequencer and the decoder:
// sub-state encodings, opcode (opr) values and the two-cycle predicate.
package instr_sequencer_pkg;

  typedef enum logic [2:0] {
    CYC_A1 = 3'd0,
    CYC_A2 = 3'd1,
    CYC_A3 = 3'd2,
    CYC_M1 = 3'd3,
    CYC_M2 = 3'd4,
    CYC_X1 = 3'd5,
    CYC_X2 = 3'd6,
    CYC_X3 = 3'd7
  } cycle_e;

  localparam logic [3:0] OPR_JCN = 4'h1;
  localparam logic [3:0] OPR_FIM = 4'h2;  // FIM when opa[0]=0, SRC otherwise
  localparam logic [3:0] OPR_FIN = 4'h3;  // FIN when opa[0]=0, JIN otherwise
  localparam logic [3:0] OPR_JUN = 4'h4;
  localparam logic [3:0] OPR_JMS = 4'h5;
  localparam logic [3:0] OPR_ISZ = 4'h7;
  localparam logic [3:0] OPR_BBL = 4'hC;

  // True when the instruction occupies two machine cycles.
  function automatic logic isTwoCycle(input logic [3:0] oprV, input logic [3:0] opaV);
    logic two;
    case (oprV)
      OPR_JCN, OPR_JUN, OPR_JMS, OPR_ISZ: two = 1'b1;
      OPR_FIM, OPR_FIN:                   two = ~opaV[0];
      default:                            two = 1'b0;
    endcase
    return two;
  endfunction

  // FIN fetches its second word from the page of pc at the register-pair offset.
  function automatic logic isFin(input logic [3:0] oprV, input logic [3:0] opaV);
    return (oprV == OPR_FIN) && (opaV[0] == 1'b0);
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// ROM port of the sequencer: address nibbles out, read strobe out, data nibble in.
interface instr_sequencer_if;
  logic [3:0] romAddr;
  logic       romRe;
  logic [3:0] romData;

  modport master (output romAddr, output romRe, input romData);
  modport slave  (input romAddr, input romRe, output romData);
endinterface

// File: rtl/instr_sequencer_pc_stack.sv
// Circular return-address store for JMS/BBL. Overflow overwrites the oldest
// entry and underflow simply returns whatever the addressed entry holds.
module pc_stack #(
  parameter int DEPTH = 3
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        push,
  input  logic        pop,
  input  logic [11:0] pushData,
  output logic [11:0] popData
);
  localparam int SpW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SpW-1:0] spR;
  logic [SpW-1:0] spIncS;
  logic [SpW-1:0] spDecS;
  logic [11:0]    entryR [DEPTH];

  // Modulo-DEPTH neighbours of the stack pointer.
  always_comb begin
    if (spR == SpW'(DEPTH - 1)) begin
      spIncS = '0;
    end else begin
      spIncS = spR + SpW'(1);
    end
    if (spR == '0) begin
      spDecS = SpW'(DEPTH - 1);
    end else begin
      spDecS = spR - SpW'(1);
    end
  end

  // A pop reads the entry below the pointer in the same cycle it moves there.
  assign popData = entryR[spDecS];

  // Pointer and entry storage; push writes at sp, pop only moves sp.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      spR <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entryR[i] <= 12'd0;
      end
    end else if (push) begin
      entryR[spR] <= pushData;
      spR         <= spIncS;
    end else if (pop) begin
      spR <= spDecS;
    end else begin
      spR <= spR;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// 4004 machine-cycle sequencer: sub-state counter, ROM address nibbles,
// opcode/second-word latches, program counter and jump/call/return resolution.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int STACK_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              stepEn,
  instr_sequencer_if.master rom,
  input  logic              ccIn,
  input  logic              iszNonZero,
  input  logic [7:0]        pairIn,
  output logic [2:0]        cycle,
  output logic              sync,
  output logic [3:0]        opr,
  output logic [3:0]        opa,
  output logic [7:0]        word2,
  output logic              secondCycle,
  output logic              instrDone,
  output logic [11:0]       pc
);

  cycle_e      cycleR;
  cycle_e      cycleNextS;
  logic        secondCycleR;
  logic        secondNextS;
  logic        finalS;
  logic        retireS;
  logic        finCycleS;
  logic [3:0]  oprR;
  logic [3:0]  oprNextS;
  logic [3:0]  opaR;
  logic [3:0]  opaNextS;
  logic [7:0]  word2R;
  logic [7:0]  word2NextS;
  logic [11:0] pcR;
  logic [11:0] pcNextS;
  logic [11:0] popDataS;
  logic [11:0] addrS;
  logic        pushS;
  logic        popS;
  logic        syncR;
  logic        syncNextS;
  logic        romReR;
  logic        romReNextS;
  logic        instrDoneR;
  logic        instrDoneNextS;
  logic [3:0]  romAddrR;
  logic [3:0]  romAddrNextS;

  // The current machine cycle ends the instruction unless it is the first of two.
  assign finalS    = secondCycleR | ~isTwoCycle(oprR, opaR);
  assign finCycleS = secondCycleR & isFin(oprR, opaR);

  pc_stack #(.DEPTH(STACK_DEPTH)) uStack (
    .clk      (clk),
    .rstN     (rstN),
    .push     (pushS),
    .pop      (popS),
    .pushData (pcR),
    .popData  (popDataS)
  );

  // Sub-state register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cycleR       <= CYC_A1;
      secondCycleR <= 1'b0;
    end else begin
      cycleR       <= cycleNextS;
      secondCycleR <= secondNextS;
    end
  end

  // Next sub-state: free-running except at an instruction boundary without stepEn.
  always_comb begin
    cycleNextS  = cycleR;
    secondNextS = secondCycleR;
    retireS     = 1'b0;
    if (cycleR == CYC_X3) begin
      if (!finalS) begin
        cycleNextS  = CYC_A1;
        secondNextS = 1'b1;
      end else if (stepEn) begin
        cycleNextS  = CYC_A1;
        secondNextS = 1'b0;
        retireS     = 1'b1;
      end else begin
        cycleNextS  = CYC_X3;
        secondNextS = secondCycleR;
      end
    end else begin
      cycleNextS  = cycle_e'(cycleR + 3'd1);
      secondNextS = secondCycleR;
    end
  end

  // Next port values, computed from the upcoming sub-state so they register cleanly.
  always_comb begin
    syncNextS      = (cycleNextS == CYC_X3);
    romReNextS     = (cycleNextS == CYC_M1) || (cycleNextS == CYC_M2);
    instrDoneNextS = (cycleR == CYC_X2) && finalS;
    if (secondNextS && isFin(oprNextS, opaNextS)) begin
      addrS = {pcNextS[11:8], pairIn};
    end else begin
      addrS = pcNextS;
    end
    case (cycleNextS)
      CYC_A1:  romAddrNextS = addrS[3:0];
      CYC_A2:  romAddrNextS = addrS[7:4];
      CYC_A3:  romAddrNextS = addrS[11:8];
      default: romAddrNextS = 4'd0;
    endcase
  end

  // Registered port outputs.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      syncR      <= 1'b0;
      romReR     <= 1'b0;
      instrDoneR <= 1'b0;
      romAddrR   <= 4'd0;
    end else begin
      syncR      <= syncNextS;
      romReR     <= romReNextS;
      instrDoneR <= instrDoneNextS;
      romAddrR   <= romAddrNextS;
    end
  end

  // Opcode/word2 capture, pc increment and the X3 jump/call/return resolution.
  always_comb begin
    oprNextS   = oprR;
    opaNextS   = opaR;
    word2NextS = word2R;
    pcNextS    = pcR;
    pushS      = 1'b0;
    popS       = 1'b0;
    case (cycleR)
      CYC_M1: begin
        if (secondCycleR) begin
          word2NextS[7:4] = rom.romData;
        end else begin
          oprNextS = rom.romData;
        end
      end
      CYC_M2: begin
        if (secondCycleR) begin
          word2NextS[3:0] = rom.romData;
        end else begin
          opaNextS = rom.romData;
        end
        if (finCycleS) begin
          pcNextS = pcR;
        end else begin
          pcNextS = pcR + 12'd1;
        end
      end
      CYC_X3: begin
        if (retireS) begin
          case (oprR)
            OPR_JUN: pcNextS = {opaR, word2R};
            OPR_JMS: begin
              pushS   = 1'b1;
              pcNextS = {opaR, word2R};
            end
            OPR_JCN: pcNextS = ccIn ? {pcR[11:8], word2R} : pcR;
            OPR_ISZ: pcNextS = iszNonZero ? {pcR[11:8], word2R} : pcR;
            OPR_FIN: pcNextS = opaR[0] ? {pcR[11:8], pairIn} : pcR;
            OPR_BBL: begin
              popS    = 1'b1;
              pcNextS = popDataS;
            end
            default: pcNextS = pcR;
          endcase
        end else begin
          pcNextS = pcR;
        end
      end
      default: pcNextS = pcR;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      oprR   <= 4'd0;
      opaR   <= 4'd0;
      word2R <= 8'd0;
      pcR    <= 12'd0;
    end else begin
      oprR   <= oprNextS;
      opaR   <= opaNextS;
      word2R <= word2NextS;
      pcR    <= pcNextS;
    end
  end

  assign cycle       = cycleR;
  assign sync        = syncR;
  assign opr         = oprR;
  assign opa         = opaR;
  assign word2       = word2R;
  assign secondCycle = secondCycleR;
  assign instrDone   = instrDoneR;
  assign pc          = pcR;
  assign rom.romAddr = romAddrR;
  assign rom.romRe   = romReR;

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

- Machine-cycle sequencer for the 4004 core.
- Generates the 8-state cycle count (A1..X3) that the decoder and ALU consume.
- Drives ROM address nibbles, latches the opcode nibbles (opr/opa) and the second word of two-word instructions, and owns the 12-bit program counter and the 3-level return stack.
- Sits between the ROM port and `decoderWithCc`; resolves jumps, calls and returns at X3.

## Interface
Parameters:
- STACK_DEPTH, 3, number of return-stack entries.

Ports:
- clk  in  1  core clock; one cycle = one 4004 sub-state.
- rstN  in  1  asynchronous, active-low reset.
- stepEn  in  1  permits starting a new instruction; sampled at X3 of an instruction's final machine cycle.
- romData  in  4  ROM nibble; valid in M1 and M2.
- ccIn  in  1  JCN condition result (decoder CCout).
- iszNonZero  in  1  ISZ incremented register ≠ 0; valid in X3 of the second cycle.
- pairIn  in  8  register-pair value for FIN/JIN.
- cycle  out  3  0=A1 1=A2 2=A3 3=M1 4=M2 5=X1 6=X2 7=X3.
- sync  out  1  high while cycle==7.
- romAddr  out  4  address nibble during A1..A3, 0 otherwise.
- romRe  out  1  high in M1 and M2.
- opr  out  4  first-word upper nibble.
- opa  out  4  first-word lower nibble.
- word2  out  8  second word: fetched byte for JCN/FIM/JUN/JMS/ISZ, ROM data for FIN.
- secondCycle  out  1  current machine cycle is the 2nd of a two-cycle instruction.
- instrDone  out  1  one-clock pulse at X3 of an instruction's final machine cycle.
- pc  out  12  program counter.

## Operation
- **Cycle counter:** 0→7 then wraps to 0.
  - At an instruction boundary (cycle 7, secondCycle=0 after the 1st cycle of a one-cycle instruction, or secondCycle=1) the advance to A1 requires stepEn=1.
  - Otherwise the counter holds at 7 with sync high, and X3 actions are deferred until the advance.
- **Address nibbles:** A1 = addr[3:0], A2 = addr[7:4], A3 = addr[11:8].
  - addr = pc, except in the FIN second cycle, where addr = {pc[11:8], pairIn}.
- **First cycle:**
  - opr ← romData at end of M1.
  - opa ← romData at end of M2.
  - pc ← pc+1 (mod 4096) at end of M2.
- **Two-cycle instructions:**
  - JCN (1), FIM (2, opa[0]=0), FIN (3, opa[0]=0), JUN (4), JMS (5), ISZ (7).
  - At the end of the first X3, secondCycle ← 1.
  - In the second cycle, opr/opa hold.
  - word2[7:4] ← romData at end of M1; word2[3:0] at end of M2.
  - pc increments at end of M2, except for FIN (pc unchanged).
- **X3 resolution** (applied on the 7→0 transition of the final cycle):
  - JUN: pc ← {opa, word2}.
  - JMS: push pc (already past word 2); pc ← {opa, word2}.
  - JCN: if ccIn, pc ← {pc[11:8], word2}.
  - ISZ: if iszNonZero, pc ← {pc[11:8], word2}.
  - JIN (3, opa[0]=1, one cycle): pc ← {pc[11:8], pairIn}.
  - BBL (C): pop into pc.
  - All others: no pc change.
- **Stack:**
  - Circular, STACK_DEPTH entries, with pointer sp.
  - Push writes entry[sp], then sp ← sp+1 mod depth. A 4th push overwrites the oldest entry.
  - Pop does sp ← sp−1 mod depth and reads entry[sp]. Underflow returns whatever that entry holds; no error is raised.
- **Reset values:**
  - cycle=0, sync=0, romAddr=0, romRe=0.
  - opr=opa=0, word2=0, secondCycle=0, instrDone=0.
  - pc=0, sp=0, all stack entries 0.
  - An assertion mid-instruction aborts it immediately; no pending pc update is applied.

## Timing
- First opcode fetch after reset release: A1..A3 emit 0,0,0; opr valid from cycle 4, opa from cycle 5.
- opr/opa are stable from X1 through X3 of every machine cycle of the instruction.
- word2 is stable from X1 of the second cycle.
- New pc is visible at A1 of the next instruction. The branch-taken penalty is zero beyond the instruction's own machine cycles.
- instrDone is coincident with sync of the final machine cycle. While held by stepEn=0, it pulses only on the first clock of X3.
- ccIn and iszNonZero are sampled on the 7→0 transition only.

## Structure
- Shared package holds:
  - cycle encodings (A1..X3);
  - opr codes (JCN, FIM/SRC, FIN/JIN, JUN, JMS, ISZ, BBL);
  - the two-cycle predicate as a function of opr/opa, shared with the decoder.
- Sub-module `pc_stack`: circular push/pop store, 12-bit entries, STACK_DEPTH deep, with the async active-low reset.

## Test plan
- **Linear fetch:** ROM 0x000=0xD5 (LDM 5), 0x001=0x00, stepEn=1.
  - romAddr sequence 0,0,0 then 1,0,0.
  - opr=D, opa=5 at X1.
  - instrDone each 8 clocks; pc 0→1→2.
- **JUN:** 0x000=0x41, 0x001=0x23.
  - secondCycle=1 in the 2nd cycle, word2=0x23.
  - Next A1..A3 emit 3,2,1 (pc=0x123).
- **JMS/BBL and overflow:** JMS at 0x010→0x200, then BBL → pc=0x012. Then 4 nested JMS and 4 BBL: the 4th return equals the 4th call's return address (wrap).
- **JCN:** at 0x0FE with word2=0x40.
  - ccIn=1 → pc=0x140 (page of incremented pc).
  - ccIn=0 → pc=0x100.
- **FIN:** at 0x050 with pairIn=0x7A.
  - 2nd cycle addresses 0xA,0x7,0x0.
  - word2=ROM[0x07A]; pc=0x051 after.
- **stepEn hold + reset:**
  - stepEn=0 at X3 → cycle held at 7 for N clocks, single instrDone pulse.
  - rstN low during M2 → all outputs return to reset values asynchronously; pc=0.
